nes_controller_emu: RTL and testbench

//  Controller-side (responder) end of the NES serial pad protocol: emulates a 4021-style pad.

---
 rtl/nes_controller_emu.sv | 128 ++++++++++++
 tb/tb_nes_controller_emu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nes_controller_emu.sv
// Responder end of the NES serial pad link: behaves like a 4021 shift register.
// It latches the live buttons while the host holds latch, then shifts them out active-low.
module nes_controller_emu #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       latch_in,
  input  logic       nes_clk_in,
  input  logic [7:0] buttons,
  output logic       data_out,
  output logic [3:0] bit_cnt,
  output logic       frame_done
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] latch_sync_q, nclk_sync_q;
  logic                   latch_hist_q, nclk_hist_q;
  logic [7:0]             shreg_q, shreg_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic                   frame_done_q, frame_done_d;
  logic [TW-1:0]          tmo_q, tmo_d;

  logic latch_s, nclk_s;
  logic latch_rise, latch_fall, nclk_rise;

  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign nclk_s     = nclk_sync_q[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_hist_q;
  assign latch_fall = ~latch_s & latch_hist_q;
  assign nclk_rise  = nclk_s & ~nclk_hist_q;

  // Synchronizers plus one history flop each; only synchronized copies reach the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_sync_q <= '0;
      nclk_sync_q  <= '0;
      latch_hist_q <= 1'b0;
      nclk_hist_q  <= 1'b0;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], latch_in};
      nclk_sync_q  <= {nclk_sync_q[SYNC_STAGES-2:0], nes_clk_in};
      latch_hist_q <= latch_s;
      nclk_hist_q  <= nclk_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= 8'hFF;
      bit_cnt_q    <= 4'd0;
      frame_done_q <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
      tmo_q        <= tmo_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    tmo_d        = tmo_q;

    unique case (state_q)
      IDLE: ;
      LOAD: begin
        shreg_d   = ~buttons;
        bit_cnt_d = 4'd0;
        tmo_d     = '0;
        // A host clock coinciding with the latch fall is not counted.
        if (latch_fall) state_d = SHIFT;
      end
      SHIFT: begin
        if (nclk_rise) begin
          shreg_d   = {shreg_q[6:0], 1'b1};
          bit_cnt_d = bit_cnt_q + 4'd1;
          tmo_d     = '0;
          if (bit_cnt_q == 4'd7) begin
            frame_done_d = 1'b1;
            state_d      = DONE;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          shreg_d = 8'hFF;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: begin
        if (nclk_rise) shreg_d = {shreg_q[6:0], 1'b1};
      end
      default: state_d = IDLE;
    endcase

    // Latch rise wins over everything, including a same-cycle host clock edge.
    if (latch_rise) begin
      state_d      = LOAD;
      shreg_d      = ~buttons;
      bit_cnt_d    = 4'd0;
      frame_done_d = 1'b0;
      tmo_d        = '0;
    end
  end

  assign data_out   = shreg_q[7];
  assign bit_cnt    = bit_cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_nes_controller_emu.sv
// Scoreboard bench for nes_controller_emu: stimulus queues expectations, a monitor compares.
module tb_nes_controller_emu;

  localparam int TIMEOUT = 4096;
  localparam int HALF    = 8;

  logic       clk;
  logic       reset;
  logic       latch_in;
  logic       nes_clk_in;
  logic [7:0] buttons;
  logic       data_out;
  logic [3:0] bit_cnt;
  logic       frame_done;

  nes_controller_emu #(.SYNC_STAGES(2), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .latch_in  (latch_in),
    .nes_clk_in(nes_clk_in),
    .buttons   (buttons),
    .data_out  (data_out),
    .bit_cnt   (bit_cnt),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       d;
    logic [3:0] cnt;
    int         fd;
  } exp_t;

  exp_t exp_q[$];
  logic chk_req = 1'b0;
  int   total   = 0;
  int   bad     = 0;
  int   fd_seen = 0;

  // Monitor: counts frame_done pulses and checks outputs when a check is requested.
  always @(negedge clk) begin
    exp_t e;
    if (frame_done === 1'b1) fd_seen = fd_seen + 1;
    if (chk_req) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL scoreboard_empty: no expectation queued");
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e.d || bit_cnt !== e.cnt || fd_seen != e.fd) begin
          bad = bad + 1;
          $display("FAIL %s: got data_out=%b bit_cnt=%0d frames=%0d, want data_out=%b bit_cnt=%0d frames=%0d",
                   e.name, data_out, bit_cnt, fd_seen, e.d, e.cnt, e.fd);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input logic d, input logic [3:0] cnt, input int fd);
    exp_t e;
    e.name = name; e.d = d; e.cnt = cnt; e.fd = fd;
    exp_q.push_back(e);
    chk_req = 1'b1;
    cyc(1);
    chk_req = 1'b0;
  endtask

  task automatic host_clk();
    nes_clk_in = 1'b1;
    cyc(HALF);
    nes_clk_in = 1'b0;
    cyc(HALF);
  endtask

  task automatic latch_pulse();
    latch_in = 1'b1;
    cyc(HALF);
    latch_in = 1'b0;
    cyc(HALF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic seq2 [0:8];

  initial begin
    seq2 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    reset = 1'b1; latch_in = 1'b0; nes_clk_in = 1'b0; buttons = 8'h00;

    // 1: reset values, then host clocks with no latch change nothing
    cyc(3);
    expect_now("reset_values", 1'b1, 4'd0, 0);
    reset = 1'b0;
    cyc(2);
    for (int i = 0; i < 5; i++) host_clk();
    expect_now("idle_clocks_ignored", 1'b1, 4'd0, 0);

    // 2: buttons A1 -> 0,1,0,1,1,1,1,0
    buttons = 8'b1010_0001;
    latch_in = 1'b1;
    cyc(HALF);
    expect_now("t2_load_shows_notA", 1'b0, 4'd0, 0);
    latch_in = 1'b0;
    cyc(HALF);
    expect_now("t2_bit0", seq2[0], 4'd0, 0);
    for (int i = 1; i <= 8; i++) begin
      host_clk();
      expect_now($sformatf("t2_after_clk%0d", i), seq2[i], 4'(i), (i == 8) ? 1 : 0);
    end

    // 3: extra clocks shift in released bits, count saturates
    buttons = 8'h00;
    for (int i = 1; i <= 4; i++) begin
      host_clk();
      expect_now($sformatf("t3_extra_clk%0d", i), 1'b1, 4'd8, 1);
    end

    // 4: aborted frame, then a full frame of released buttons
    buttons = 8'hFF;
    latch_pulse();
    for (int i = 0; i < 3; i++) host_clk();
    expect_now("t4_partial_frame", 1'b0, 4'd3, 1);
    buttons = 8'h00;
    latch_pulse();
    expect_now("t4_relatch_bit0", 1'b1, 4'd0, 1);
    for (int i = 1; i <= 8; i++) begin
      host_clk();
      expect_now($sformatf("t4_clk%0d", i), 1'b1, 4'(i), (i == 8) ? 2 : 1);
    end

    // 5: timeout mid-shift returns to idle
    buttons = 8'h20;
    latch_pulse();
    host_clk();
    host_clk();
    expect_now("t5_before_timeout", 1'b0, 4'd2, 2);
    cyc(TIMEOUT + 10);
    expect_now("t5_after_timeout", 1'b1, 4'd2, 2);
    host_clk();
    expect_now("t5_idle_ignores_clk", 1'b1, 4'd2, 2);

    // 6: host clocks during latch are ignored
    buttons = 8'h80;
    latch_in = 1'b1;
    cyc(HALF);
    host_clk();
    expect_now("t6_clk_in_latch_1", 1'b0, 4'd0, 2);
    host_clk();
    expect_now("t6_clk_in_latch_2", 1'b0, 4'd0, 2);
    latch_in = 1'b0;
    cyc(HALF);
    expect_now("t6_after_fall", 1'b0, 4'd0, 2);
    host_clk();
    expect_now("t6_one_clk", 1'b1, 4'd1, 2);

    // Reset in the middle of a frame
    buttons = 8'hC0;
    latch_pulse();
    host_clk();
    expect_now("mid_frame_before_reset", 1'b0, 4'd1, 2);
    reset = 1'b1;
    #2;
    expect_now("mid_frame_reset", 1'b1, 4'd0, 2);
    reset = 1'b0;
    cyc(2);
    host_clk();
    expect_now("post_reset_idle", 1'b1, 4'd0, 2);

    cyc(4);
    if (exp_q.size() != 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
